demux_1x2_buffered: RTL and testbench

- Inverse of the datapath 2:1 select: steers one N-bit source stream to one of two sink ports, chosen per transfer by a select bit.
- Each sink port has its own DEPTH-entry FIFO, so a stalled sink does not block traffic to the other sink.
- Used to route one shared response stream (e.g. a memory read return) to the fetch path (port 1) or the data path (port 2).
- Valid/ready handshake on all ports; no combinational path from any out*_ready to in_ready.

---
 rtl/demux_1x2_buffered.sv | 148 ++++++++++++++
 tb/tb_demux_1x2_buffered.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x2_buffered.sv
// Steers one valid/ready stream into one of two sinks, each behind its own FIFO.
// Latency 1 cycle from accept to out*_valid; a full FIFO lowers in_ready only for its own select value.

module demux_1x2_buffered_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [N-1:0] wdata_i,
    input  logic         pop_i,
    output logic [N-1:0] rdata_o,
    output logic         valid_o,
    output logic         full_o
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [N-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            full_q, full_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop_i) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNTW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = valid_o ? mem_q[rptr_q] : '0;
    assign full_o  = full_q;
endmodule

module demux_1x2_buffered #(
    parameter int N     = 32,
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in_data,
    input  logic          in_sel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  out1_data,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [N-1:0]  out2_data,
    output logic          out2_valid,
    input  logic          out2_ready,
    output logic [CW-1:0] cnt1,
    output logic [CW-1:0] cnt2
);
    logic          full1, full2;
    logic          push1, push2;
    logic          pop1, pop2;
    logic [CW-1:0] cnt1_q, cnt1_d;
    logic [CW-1:0] cnt2_q, cnt2_d;

    // Only registered full flags feed in_ready, so sink readies never reach the source.
    assign in_ready = !rst && (in_sel ? !full2 : !full1);
    assign push1    = in_valid && in_ready && !in_sel;
    assign push2    = in_valid && in_ready && in_sel;
    assign pop1     = out1_valid && out1_ready;
    assign pop2     = out2_valid && out2_ready;

    demux_1x2_buffered_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push1),
        .wdata_i (in_data),
        .pop_i   (pop1),
        .rdata_o (out1_data),
        .valid_o (out1_valid),
        .full_o  (full1)
    );

    demux_1x2_buffered_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo2 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push2),
        .wdata_i (in_data),
        .pop_i   (pop2),
        .rdata_o (out2_data),
        .valid_o (out2_valid),
        .full_o  (full2)
    );

    always_comb begin
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        if (pop1) begin
            cnt1_d = cnt1_q + CW'(1);
        end
        if (pop2) begin
            cnt2_d = cnt2_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

    assign cnt1 = cnt1_q;
    assign cnt2 = cnt2_q;
endmodule

// File: tb/tb_demux_1x2_buffered.sv
// Bench for demux_1x2_buffered: directed scenarios plus a randomized stream against a queue model.
module tb_demux_1x2_buffered;
    localparam int N     = 32;
    localparam int DEPTH = 2;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  in_data;
    logic          in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  out1_data;
    logic          out1_valid;
    logic          out1_ready;
    logic [N-1:0]  out2_data;
    logic          out2_valid;
    logic          out2_ready;
    logic [CW-1:0] cnt1;
    logic [CW-1:0] cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one queue per sink, plain handshake counts.
    logic [N-1:0] q1[$];
    logic [N-1:0] q2[$];
    int m_cnt1 = 0;
    int m_cnt2 = 0;
    int m_pops = 0;

    always #5 clk = ~clk;

    demux_1x2_buffered #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .cnt1       (cnt1),
        .cnt2       (cnt2)
    );

    task automatic drive(input logic r, input logic v, input logic s, input logic [N-1:0] d,
                         input logic or1, input logic or2);
        rst = r; in_valid = v; in_sel = s; in_data = d; out1_ready = or1; out2_ready = or2;
        #1;
    endtask

    // Advance one clock edge and update the model from the inputs offered before it.
    task automatic advance();
        logic         r, acc1, acc2, pop1, pop2;
        logic [N-1:0] d;
        r    = rst;
        d    = in_data;
        pop1 = out1_ready && (q1.size() > 0);
        pop2 = out2_ready && (q2.size() > 0);
        acc1 = in_valid && !in_sel && (q1.size() < DEPTH);
        acc2 = in_valid && in_sel && (q2.size() < DEPTH);
        @(posedge clk);
        if (r) begin
            q1.delete(); q2.delete(); m_cnt1 = 0; m_cnt2 = 0;
        end else begin
            if (pop1) begin void'(q1.pop_front()); m_cnt1++; m_pops++; end
            if (pop2) begin void'(q2.pop_front()); m_cnt2++; m_pops++; end
            if (acc1) q1.push_back(d);
            if (acc2) q2.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 'x, 0, 0);
        advance(); advance();
        drive(1, 0, 0, 'x, 0, 0);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_sel0 got=%b exp=0", in_ready); end
        drive(1, 0, 1, 'x, 0, 0);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_sel1 got=%b exp=0", in_ready); end
        n_checks++; if ({out1_valid, out2_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_valids got=%b exp=00", {out1_valid, out2_valid}); end
        drive(0, 0, 0, 'x, 0, 0);
        for (int i = 0; i < 5; i++) advance();
        n_checks++; if ({out1_valid, out2_valid} !== 2'b00) begin n_fail++; $display("FAIL idle_valids got=%b exp=00", {out1_valid, out2_valid}); end
        n_checks++; if (out1_data !== '0 || out2_data !== '0) begin n_fail++; $display("FAIL idle_data got=%h/%h exp=0/0", out1_data, out2_data); end
        n_checks++; if (cnt1 !== '0 || cnt2 !== '0) begin n_fail++; $display("FAIL idle_cnt got=%0d/%0d exp=0/0", cnt1, cnt2); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready_sel0 got=%b exp=1", in_ready); end
        drive(0, 0, 1, 'x, 0, 0);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready_sel1 got=%b exp=1", in_ready); end
    endtask

    task automatic test_routing();
        drive(0, 1, 0, 32'hA5A5_A5A5, 1, 0);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL route1_ready got=%b exp=1", in_ready); end
        advance();
        drive(0, 0, 0, 'x, 1, 0);
        n_checks++; if (out1_valid !== 1'b1 || out1_data !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL route1_out got=%b/%h exp=1/a5a5a5a5", out1_valid, out1_data); end
        n_checks++; if (out2_valid !== 1'b0 || out2_data !== '0) begin n_fail++; $display("FAIL route1_p2idle got=%b/%h exp=0/0", out2_valid, out2_data); end
        n_checks++; if (cnt1 !== 4'd0) begin n_fail++; $display("FAIL route1_cnt_pre got=%0d exp=0", cnt1); end
        advance();
        n_checks++; if (out1_valid !== 1'b0 || out1_data !== '0) begin n_fail++; $display("FAIL route1_gone got=%b/%h exp=0/0", out1_valid, out1_data); end
        n_checks++; if (cnt1 !== 4'd1 || cnt2 !== 4'd0) begin n_fail++; $display("FAIL route1_cnt got=%0d/%0d exp=1/0", cnt1, cnt2); end
        drive(0, 1, 1, 32'h5A5A_5A5A, 0, 1);
        advance();
        drive(0, 0, 1, 'x, 0, 1);
        n_checks++; if (out2_valid !== 1'b1 || out2_data !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL route2_out got=%b/%h exp=1/5a5a5a5a", out2_valid, out2_data); end
        n_checks++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL route2_p1idle got=%b exp=0", out1_valid); end
        advance();
        n_checks++; if (out2_valid !== 1'b0) begin n_fail++; $display("FAIL route2_gone got=%b exp=0", out2_valid); end
        n_checks++; if (cnt1 !== 4'd1 || cnt2 !== 4'd1) begin n_fail++; $display("FAIL route2_cnt got=%0d/%0d exp=1/1", cnt1, cnt2); end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] w[3];
        logic [N-1:0] v[4];
        for (int i = 0; i < 3; i++) w[i] = $urandom;
        for (int i = 0; i < 4; i++) v[i] = $urandom;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, w[i], 0, 1);
            n_checks++; if (in_ready !== (i < 2)) begin n_fail++; $display("FAIL bp_ready%0d got=%b exp=%b", i, in_ready, (i < 2)); end
            if (i < 2) advance();
        end
        n_checks++; if (out1_valid !== 1'b1 || out1_data !== w[0]) begin n_fail++; $display("FAIL bp_head got=%b/%h exp=1/%h", out1_valid, out1_data, w[0]); end
        for (int j = 0; j < 4; j++) begin
            drive(0, 1, 1, v[j], 0, 1);
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_p2ready%0d got=%b exp=1", j, in_ready); end
            if (j > 0) begin
                n_checks++; if (out2_valid !== 1'b1 || out2_data !== v[j-1]) begin n_fail++; $display("FAIL bp_p2flow%0d got=%b/%h exp=1/%h", j, out2_valid, out2_data, v[j-1]); end
            end
            advance();
        end
        drive(0, 0, 0, 'x, 1, 1);
        n_checks++; if (out2_data !== v[3]) begin n_fail++; $display("FAIL bp_p2last got=%h exp=%h", out2_data, v[3]); end
        n_checks++; if (out1_data !== w[0]) begin n_fail++; $display("FAIL bp_rel0 got=%h exp=%h", out1_data, w[0]); end
        advance();
        n_checks++; if (out1_valid !== 1'b1 || out1_data !== w[1]) begin n_fail++; $display("FAIL bp_rel1 got=%b/%h exp=1/%h", out1_valid, out1_data, w[1]); end
        advance();
        n_checks++; if ({out1_valid, out2_valid} !== 2'b00) begin n_fail++; $display("FAIL bp_drained got=%b exp=00", {out1_valid, out2_valid}); end
        n_checks++; if (cnt1 !== 4'd3 || cnt2 !== 4'd5) begin n_fail++; $display("FAIL bp_cnt got=%0d/%0d exp=3/5", cnt1, cnt2); end
    endtask

    task automatic test_full_boundary();
        logic [N-1:0] a, b, c;
        a = $urandom; b = $urandom; c = $urandom;
        drive(0, 1, 0, a, 0, 0); advance();
        drive(0, 1, 0, b, 0, 0); advance();
        drive(0, 1, 0, c, 1, 0);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_refuse got=%b exp=0", in_ready); end
        n_checks++; if (out1_data !== a) begin n_fail++; $display("FAIL full_head got=%h exp=%h", out1_data, a); end
        advance();
        drive(0, 1, 0, c, 0, 0);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_reopen got=%b exp=1", in_ready); end
        n_checks++; if (out1_data !== b) begin n_fail++; $display("FAIL full_head2 got=%h exp=%h", out1_data, b); end
        advance();
        drive(0, 0, 0, 'x, 0, 0);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_again got=%b exp=0", in_ready); end
        drive(0, 0, 0, 'x, 1, 0);
        advance();
        n_checks++; if (out1_valid !== 1'b1 || out1_data !== c) begin n_fail++; $display("FAIL full_tail got=%b/%h exp=1/%h", out1_valid, out1_data, c); end
        advance();
        n_checks++; if (out1_valid !== 1'b0 || cnt1 !== 4'd6) begin n_fail++; $display("FAIL full_end got=%b/%0d exp=0/6", out1_valid, cnt1); end
    endtask

    task automatic test_stream();
        int           sent = 0;
        int           cyc = 0;
        int           pops0;
        bit           pend = 0;
        logic         psel = 0;
        logic [N-1:0] pdat = '0;
        logic         exp_rdy;
        logic [N-1:0] e1, e2;
        logic [CW-1:0] prev1;
        bit           wrap_seen = 0;
        pops0 = m_pops;
        prev1 = cnt1;
        while (sent < 1000 && cyc < 20000) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1; psel = sent[0]; pdat = $urandom;
            end
            drive(0, pend, psel, pend ? pdat : 'x, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            exp_rdy = psel ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
            e1 = (q1.size() > 0) ? q1[0] : '0;
            e2 = (q2.size() > 0) ? q2[0] : '0;
            n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL st_ready c%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
            n_checks++; if (out1_valid !== (q1.size() > 0) || out1_data !== e1) begin n_fail++; $display("FAIL st_out1 c%0d got=%b/%h exp=%b/%h", cyc, out1_valid, out1_data, (q1.size() > 0), e1); end
            n_checks++; if (out2_valid !== (q2.size() > 0) || out2_data !== e2) begin n_fail++; $display("FAIL st_out2 c%0d got=%b/%h exp=%b/%h", cyc, out2_valid, out2_data, (q2.size() > 0), e2); end
            n_checks++; if (cnt1 !== CW'(m_cnt1) || cnt2 !== CW'(m_cnt2)) begin n_fail++; $display("FAIL st_cnt c%0d got=%0d/%0d exp=%0d/%0d", cyc, cnt1, cnt2, CW'(m_cnt1), CW'(m_cnt2)); end
            if (prev1 == 4'd15 && cnt1 == 4'd0) wrap_seen = 1;
            prev1 = cnt1;
            if (pend && exp_rdy) begin pend = 0; sent++; end
            advance();
            cyc++;
        end
        n_checks++; if (sent != 1000) begin n_fail++; $display("FAIL st_budget got=%0d exp=1000", sent); end
        drive(0, 0, 0, 'x, 1, 1);
        for (int i = 0; i < 4; i++) advance();
        n_checks++; if ({out1_valid, out2_valid} !== 2'b00) begin n_fail++; $display("FAIL st_drain got=%b exp=00", {out1_valid, out2_valid}); end
        n_checks++; if (CW'(cnt1 + cnt2) !== CW'(m_cnt1 + m_cnt2)) begin n_fail++; $display("FAIL st_sum got=%0d exp=%0d", CW'(cnt1 + cnt2), CW'(m_cnt1 + m_cnt2)); end
        n_checks++; if (m_pops - pops0 < 1000) begin n_fail++; $display("FAIL st_handshakes got=%0d exp=1000", m_pops - pops0); end
        n_checks++; if (!wrap_seen) begin n_fail++; $display("FAIL st_wrap got=0 exp=1"); end
    endtask

    task automatic test_mid_reset();
        logic [N-1:0] f;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, i >= 2, $urandom, 0, 0);
            advance();
        end
        n_checks++; if ({out1_valid, out2_valid} !== 2'b11) begin n_fail++; $display("FAIL mr_full got=%b exp=11", {out1_valid, out2_valid}); end
        drive(1, 1, 0, $urandom, 1, 1);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mr_ready got=%b exp=0", in_ready); end
        advance();
        drive(0, 0, 0, 'x, 1, 1);
        n_checks++; if ({out1_valid, out2_valid} !== 2'b00 || out1_data !== '0 || out2_data !== '0) begin n_fail++; $display("FAIL mr_clear got=%b/%h/%h exp=00/0/0", {out1_valid, out2_valid}, out1_data, out2_data); end
        n_checks++; if (cnt1 !== '0 || cnt2 !== '0) begin n_fail++; $display("FAIL mr_cnt got=%0d/%0d exp=0/0", cnt1, cnt2); end
        for (int i = 0; i < 4; i++) begin
            advance();
            n_checks++; if ({out1_valid, out2_valid} !== 2'b00) begin n_fail++; $display("FAIL mr_stale%0d got=%b exp=00", i, {out1_valid, out2_valid}); end
        end
        f = $urandom;
        drive(0, 1, 0, f, 0, 1);
        advance();
        drive(0, 0, 0, 'x, 0, 1);
        n_checks++; if (out1_valid !== 1'b1 || out1_data !== f || out2_valid !== 1'b0) begin n_fail++; $display("FAIL mr_fresh got=%b/%h/%b exp=1/%h/0", out1_valid, out1_data, out2_valid, f); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0; out1_ready = 1'b0; out2_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_routing();
        test_backpressure();
        test_full_boundary();
        test_stream();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
